board_input_port: RTL
=====================

# board_input_port

Input-side companion to the LED output wrapper. Synchronizes and debounces raw board buttons and switches, records rising and falling events in sticky flags, and exposes everything to the simpleRisc core through a small read-only register port. The port sits between the board pins and the CPU's load path. An optional interrupt request is raised on pending press events.

## Interface
- `N_IN`, 4: number of raw inputs (1..16).
- `DEBOUNCE_CYCLES`, 50000: consecutive cycles a synchronized input must differ from the stable value before the stable value changes (≥1).
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pin_in` in N_IN: raw asynchronous button/switch levels.
- `rd_en` in 1: read strobe, one cycle per request.
- `rd_addr` in 2: register select.
- `rd_data` out 32: read result, valid only while `rd_valid` is high.
- `rd_valid` out 1: single-cycle pulse, one cycle after `rd_en`.
- `irq` out 1: press-pending request; exists only with `BOARD_INPUT_IRQ_EN`.

## Operation
- Each input passes through a 2-flop synchronizer (`sync1` → `sync2`).
- Each input has a debounce counter of width clog2(DEBOUNCE_CYCLES+1):
  - If `sync2` equals `stable`, the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, `stable` takes `sync2` and the counter clears.
- Rising event: `stable` goes 0→1; the bit's `rise_flag` sets on the same edge. Falling events set `fall_flag` the same way.
- Register map (all fields are zero-extended to 32 bits):
  - 0: `stable`, the debounced levels.
  - 1: `rise_flag`, clear-on-read.
  - 2: `fall_flag`, clear-on-read.
  - 3: `press_count`, a 16-bit count of rising events. It is not cleared on read.
- Clear-on-read:
  - The returned value is the flag vector before the read.
  - The register clears on the edge that latches `rd_data`.
  - If a new event for a bit occurs on that same edge, the flag stays set, and the returned value shows the pre-event state for that bit.
- `press_count` adds the popcount of rising events each cycle (several inputs may rise together). It wraps modulo 2^16.
- `rd_en` on consecutive cycles is legal; each read gets its own `rd_valid` pulse.
- `rd_data` holds its last value when `rd_valid` is low.

## Timing
- Reset values are 0 for:
  - `sync1`, `sync2`, `stable`, counters, both flag registers, `press_count`;
  - the outputs `rd_data`, `rd_valid`, `irq`.
- Input latency: a raw change held steady first appears in `stable` exactly DEBOUNCE_CYCLES+2 rising edges later.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes `stable`.
- An input held high through reset release produces one rising event after DEBOUNCE_CYCLES+2 cycles, and that event is counted.
- Read latency is 1 cycle: `rd_en` sampled at edge k gives `rd_data`/`rd_valid` valid after edge k.
- Reset asserted mid-debounce or mid-read discards all state. No `rd_valid` pulse follows a read request that coincides with reset.
- `irq` is registered: it is high the cycle after any `rise_flag` bit is set, and low the cycle after all bits clear.

## Configuration
- Macro: `BOARD_INPUT_IRQ_EN`.
- When defined: the `irq` port exists and equals the registered OR of `rise_flag`.
- When undefined: the `irq` port and its register are omitted. The register map is unchanged.

## Structure
- Shared package `board_io_pkg` holds:
  - register address constants `BIP_ADDR_LEVEL`=0, `BIP_ADDR_RISE`=1, `BIP_ADDR_FALL`=2, `BIP_ADDR_COUNT`=3;
  - `BIP_DATA_W`=32;
  - `BIP_COUNT_W`=16.
- Sub-module `input_debouncer`, instantiated once per input with generate:
  - contains the synchronizer, counter and `stable` register;
  - outputs `level`, `rise_pulse` and `fall_pulse`.
- The top level holds the flags, `press_count`, the read mux and `irq`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, N_IN=4.
- Reset, then read all four addresses → `rd_data`=0 each time, `rd_valid` one cycle after each `rd_en`, `irq`=0.
- Raise `pin_in[0]` at cycle 10 and hold → `stable[0]`=1 after 6 edges, `rise_flag`=0x1, `irq`=1 next cycle. Read addr 1 → 0x1; read addr 1 again → 0x0; `irq`=0.
- Pulse `pin_in[2]` high for 3 cycles → `stable`, `rise_flag` and `fall_flag` all stay 0.
- Raise `pin_in[1]` and `pin_in[3]` together → `press_count`=2. Drop both → `fall_flag`=0xA; `press_count` still 2.
- Arrange for a read of addr 1 to land on the same edge as the rise of input 2 → returned 0x0, and a second read returns 0x4.
- Produce 65537 rising events via forced toggling → addr 3 reads 0x00000001 (wrap); assert reset mid-debounce → all registers 0 with no spurious event.

Source files
------------

// File: rtl/board_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | board_io_pkg                                                         |
// | Register map, widths and helpers shared by the board input port.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package board_io_pkg;

   localparam int BIP_DATA_W  = 32;
   localparam int BIP_COUNT_W = 16;
   localparam int BIP_ADDR_W  = 2;

   localparam logic [BIP_ADDR_W-1:0] BIP_ADDR_LEVEL = 2'd0;
   localparam logic [BIP_ADDR_W-1:0] BIP_ADDR_RISE  = 2'd1;
   localparam logic [BIP_ADDR_W-1:0] BIP_ADDR_FALL  = 2'd2;
   localparam logic [BIP_ADDR_W-1:0] BIP_ADDR_COUNT = 2'd3;

   typedef logic [BIP_DATA_W-1:0]  bip_data_t;
   typedef logic [BIP_COUNT_W-1:0] bip_count_t;

   // Number of set bits in a vector of up to 16 inputs.
   function automatic bip_count_t bip_popcount(input logic [15:0] v);
      bip_count_t n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + BIP_COUNT_W'(v[i]);
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/board_input_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | board_input_port_if                                                  |
// | Read-only register port between the CPU load path and the inputs.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface board_input_port_if;
   import board_io_pkg::*;

   logic                  rd_en;
   logic [BIP_ADDR_W-1:0] rd_addr;
   logic [BIP_DATA_W-1:0] rd_data;
   logic                  rd_valid;

   modport master (
      output rd_en,
      output rd_addr,
      input  rd_data,
      input  rd_valid
   );

   modport slave (
      input  rd_en,
      input  rd_addr,
      output rd_data,
      output rd_valid
   );

endinterface
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_debouncer                                                      |
// | Two-flop synchronizer plus counter debounce for one raw board input. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module input_debouncer
   import board_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
)
(
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic level,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             differs;
   logic             settle;

   // settle marks the edge on which the counter would reach DEBOUNCE_CYCLES.
   always_comb begin
      differs  = (sync2_q != stable_q);
      settle   = differs && (cnt_q == c_CNT_LAST);
      stable_d = stable_q;
      cnt_d    = '0;
      if (settle) begin
         stable_d = sync2_q;
      end else if (differs) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= pin_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level      = stable_q;
   assign rise_pulse = settle &  sync2_q;
   assign fall_pulse = settle & ~sync2_q;

endmodule
`default_nettype wire

// File: rtl/board_input_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | board_input_port                                                     |
// | Debounced buttons/switches with sticky edge flags and press counter, |
// | read through a small register port. BOARD_INPUT_IRQ_EN adds irq.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module board_input_port
   import board_io_pkg::*;
#(
   parameter int N_IN            = 4,
   parameter int DEBOUNCE_CYCLES = 50000
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [N_IN-1:0]     pin_in,
   board_input_port_if.slave   bus
`ifdef BOARD_INPUT_IRQ_EN
   ,
   output logic                irq
`endif
);

   logic [N_IN-1:0] level;
   logic [N_IN-1:0] rise_pulse;
   logic [N_IN-1:0] fall_pulse;

   logic [N_IN-1:0] rise_q;
   logic [N_IN-1:0] rise_d;
   logic [N_IN-1:0] fall_q;
   logic [N_IN-1:0] fall_d;
   bip_count_t      count_q;
   bip_count_t      count_d;
   bip_data_t       rd_data_q;
   bip_data_t       rd_data_d;
   logic            rd_valid_q;

   generate
      for (genvar g = 0; g < N_IN; g++) begin : g_bit
         input_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debouncer (
            .clk        (clk),
            .reset      (reset),
            .pin_i      (pin_in[g]),
            .level      (level[g]),
            .rise_pulse (rise_pulse[g]),
            .fall_pulse (fall_pulse[g])
         );
      end
   endgenerate

   // A read returns the pre-edge flags; a same-edge event is OR-ed back in after the clear.
   always_comb begin
      rise_d    = rise_q;
      fall_d    = fall_q;
      rd_data_d = rd_data_q;
      if (bus.rd_en) begin
         case (bus.rd_addr)
            BIP_ADDR_LEVEL: rd_data_d = BIP_DATA_W'(level);
            BIP_ADDR_RISE: begin
               rd_data_d = BIP_DATA_W'(rise_q);
               rise_d    = '0;
            end
            BIP_ADDR_FALL: begin
               rd_data_d = BIP_DATA_W'(fall_q);
               fall_d    = '0;
            end
            default:       rd_data_d = BIP_DATA_W'(count_q);
         endcase
      end
      rise_d  = rise_d | rise_pulse;
      fall_d  = fall_d | fall_pulse;
      count_d = count_q + bip_popcount(16'(rise_pulse));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rise_q     <= '0;
         fall_q     <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= bus.rd_en;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;

`ifdef BOARD_INPUT_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |rise_q;
      end
   end

   assign irq = irq_q;
`endif

endmodule
`default_nettype wire
